// File: rtl/axi4_frame_wdma_pkg.sv
// Shared types and AXI constants for the frame write-DMA master.
// The optional W-path skid buffer is enabled with AXI4_FRAME_WDMA_SKID_EN.
package axi4_frame_wdma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_RESP = 3'd3,
    ST_DONE = 3'd4
  } wdma_state_e;

  localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         BURST_MAX_BEATS = 8;
  localparam int         BEAT_BYTES      = 32;

endpackage

// File: rtl/axi4_wdma_skid.sv
// Two-entry valid/ready skid buffer; in_ready and the out_* side come only
// from registers, so no combinational path crosses between the two sides.
module axi4_wdma_skid #(
  parameter int W = 256
) (
  input  logic         ACLK_i,
  input  logic         ARESET_i,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] head_q, tail_q;
  logic [1:0]   cnt_q;
  logic         push, pop;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= in_data;
          else               tail_q <= in_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Head leaves while a new beat arrives: occupancy unchanged.
          if (cnt_q == 2'd1) begin
            head_q <= in_data;
          end else begin
            head_q <= tail_q;
            tail_q <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axi4_frame_wdma.sv
// AXI4 write master streaming one frame of 256-bit pixel groups as INCR bursts
// of up to 8 beats, one burst in flight. AXI4_FRAME_WDMA_SKID_EN adds a W skid buffer.
module axi4_frame_wdma
  import axi4_frame_wdma_pkg::*;
#(
  parameter int MST_ID_W          = 3,
  parameter int DATA_WIDTH        = 256,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int TRANS_WR_RESP_W   = 2,
  parameter int FRAME_BEATS_W     = 12,
  parameter int MST_ID            = 0
) (
  input  logic                         ACLK_i,
  input  logic                         ARESET_i,
  input  logic                         frame_start_i,
  input  logic [ADDR_WIDTH-1:0]        frame_base_i,
  input  logic [FRAME_BEATS_W-1:0]     frame_beats_i,
  input  logic [DATA_WIDTH-1:0]        pg_data_i,
  input  logic                         pg_valid_i,
  output logic                         pg_ready_o,
  output logic [MST_ID_W-1:0]          m_AWID_o,
  output logic [ADDR_WIDTH-1:0]        m_AWADDR_o,
  output logic [TRANS_DATA_LEN_W-1:0]  m_AWLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0] m_AWSIZE_o,
  output logic [TRANS_BURST_W-1:0]     m_AWBURST_o,
  output logic                         m_AWVALID_o,
  input  logic                         m_AWREADY_i,
  output logic [DATA_WIDTH-1:0]        m_WDATA_o,
  output logic                         m_WLAST_o,
  output logic                         m_WVALID_o,
  input  logic                         m_WREADY_i,
  input  logic [MST_ID_W-1:0]          m_BID_i,
  input  logic [TRANS_WR_RESP_W-1:0]   m_BRESP_i,
  input  logic                         m_BVALID_i,
  output logic                         m_BREADY_o,
  output logic                         busy_o,
  output logic                         frame_done_o,
  output logic                         err_o,
  output wdma_state_e                  dbg_state_o
);

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where valid and ready are both 1; a raised valid holds its payload stable
  // until that edge.

  wdma_state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [FRAME_BEATS_W-1:0]    remaining_q;
  logic [TRANS_DATA_LEN_W-1:0] beat_cnt_q, awlen;
  logic [FRAME_BEATS_W-1:0]    burst_beats;
  logic                        err_q;
  logic                        in_addr, in_data, aw_hs, w_hs, b_hs, w_last;

  assign in_addr = (state_q == ST_ADDR);
  assign in_data = (state_q == ST_DATA);

  always_comb begin
    if (remaining_q >= FRAME_BEATS_W'(BURST_MAX_BEATS))
      awlen = TRANS_DATA_LEN_W'(BURST_MAX_BEATS - 1);
    else
      awlen = TRANS_DATA_LEN_W'(remaining_q - FRAME_BEATS_W'(1));
  end
  assign burst_beats = FRAME_BEATS_W'(awlen) + FRAME_BEATS_W'(1);

  assign m_AWID_o    = MST_ID_W'(MST_ID);
  assign m_AWSIZE_o  = AXI_SIZE_32B;
  assign m_AWBURST_o = AXI_BURST_INCR;
  assign m_AWADDR_o  = in_addr ? addr_q : '0;
  assign m_AWLEN_o   = in_addr ? awlen : '0;
  assign m_WLAST_o   = in_data && (beat_cnt_q == awlen);
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

  assign aw_hs  = m_AWVALID_o && m_AWREADY_i;
  assign w_hs   = m_WVALID_o && m_WREADY_i;
  assign b_hs   = m_BVALID_i && m_BREADY_o;
  assign w_last = (beat_cnt_q == awlen);

`ifdef AXI4_FRAME_WDMA_SKID_EN
  logic [TRANS_DATA_LEN_W:0] in_cnt_q;
  logic                      accept_ok, skid_in_ready;

  // Intake is capped at the current burst length so nothing is prefetched
  // past WLAST; the buffer therefore drains empty before RESP.
  assign accept_ok  = in_data && (in_cnt_q <= {1'b0, awlen});
  assign pg_ready_o = skid_in_ready && accept_ok;

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i)                     in_cnt_q <= '0;
    else if (aw_hs)                   in_cnt_q <= '0;
    else if (pg_valid_i && pg_ready_o) in_cnt_q <= in_cnt_q + 1'b1;
  end

  axi4_wdma_skid #(.W(DATA_WIDTH)) u_skid (
    .ACLK_i    (ACLK_i),
    .ARESET_i  (ARESET_i),
    .in_data   (pg_data_i),
    .in_valid  (pg_valid_i && accept_ok),
    .in_ready  (skid_in_ready),
    .out_data  (m_WDATA_o),
    .out_valid (m_WVALID_o),
    .out_ready (m_WREADY_i)
  );
`else
  assign m_WVALID_o = pg_valid_i && in_data;
  assign pg_ready_o = m_WREADY_i && in_data;
  assign m_WDATA_o  = pg_data_i;
`endif

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (frame_start_i)
                 state_d = (frame_beats_i == '0) ? ST_DONE : ST_ADDR;
      ST_ADDR: if (aw_hs) state_d = ST_DATA;
      ST_DATA: if (w_hs && w_last) state_d = ST_RESP;
      ST_RESP: if (b_hs) state_d = (remaining_q != '0) ? ST_ADDR : ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_AWVALID_o  = 1'b0;
    m_BREADY_o   = 1'b0;
    frame_done_o = 1'b0;
    busy_o       = 1'b1;
    case (state_q)
      ST_IDLE: busy_o       = 1'b0;
      ST_ADDR: m_AWVALID_o  = 1'b1;
      ST_RESP: m_BREADY_o   = 1'b1;
      ST_DONE: frame_done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      addr_q      <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && frame_start_i) begin
        // 256 B alignment keeps every 8x32 B burst inside one 4 KB page.
        addr_q      <= {frame_base_i[ADDR_WIDTH-1:8], 8'h00};
        remaining_q <= frame_beats_i;
        err_q       <= 1'b0;
      end
      if (aw_hs) beat_cnt_q <= '0;
      if (w_hs) begin
        if (w_last) begin
          remaining_q <= remaining_q - burst_beats;
          addr_q      <= addr_q + ADDR_WIDTH'(burst_beats) * ADDR_WIDTH'(BEAT_BYTES);
        end else begin
          beat_cnt_q <= beat_cnt_q + 1'b1;
        end
      end
      if (b_hs && (m_BRESP_i != AXI_RESP_OKAY || m_BID_i != MST_ID_W'(MST_ID)))
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4_frame_wdma.sv
// Directed bench for axi4_frame_wdma: AW/W/B slave model, pixel-group source,
// and queue-based scoreboards for burst headers and data beats.
module tb_axi4_frame_wdma;
  import axi4_frame_wdma_pkg::*;

  localparam int DW  = 256;
  localparam int AWD = 32;
  localparam int FBW = 12;

  logic             ACLK_i = 1'b0;
  logic             ARESET_i;
  logic             frame_start_i;
  logic [AWD-1:0]   frame_base_i;
  logic [FBW-1:0]   frame_beats_i;
  logic [DW-1:0]    pg_data_i;
  logic             pg_valid_i;
  logic             pg_ready_o;
  logic [2:0]       m_AWID_o;
  logic [AWD-1:0]   m_AWADDR_o;
  logic [2:0]       m_AWLEN_o;
  logic [2:0]       m_AWSIZE_o;
  logic [1:0]       m_AWBURST_o;
  logic             m_AWVALID_o;
  logic             m_AWREADY_i;
  logic [DW-1:0]    m_WDATA_o;
  logic             m_WLAST_o;
  logic             m_WVALID_o;
  logic             m_WREADY_i;
  logic [2:0]       m_BID_i;
  logic [1:0]       m_BRESP_i;
  logic             m_BVALID_i;
  logic             m_BREADY_o;
  logic             busy_o;
  logic             frame_done_o;
  logic             err_o;
  wdma_state_e      dbg_state_o;

  axi4_frame_wdma dut (
    .ACLK_i(ACLK_i), .ARESET_i(ARESET_i),
    .frame_start_i(frame_start_i), .frame_base_i(frame_base_i), .frame_beats_i(frame_beats_i),
    .pg_data_i(pg_data_i), .pg_valid_i(pg_valid_i), .pg_ready_o(pg_ready_o),
    .m_AWID_o(m_AWID_o), .m_AWADDR_o(m_AWADDR_o), .m_AWLEN_o(m_AWLEN_o),
    .m_AWSIZE_o(m_AWSIZE_o), .m_AWBURST_o(m_AWBURST_o),
    .m_AWVALID_o(m_AWVALID_o), .m_AWREADY_i(m_AWREADY_i),
    .m_WDATA_o(m_WDATA_o), .m_WLAST_o(m_WLAST_o), .m_WVALID_o(m_WVALID_o), .m_WREADY_i(m_WREADY_i),
    .m_BID_i(m_BID_i), .m_BRESP_i(m_BRESP_i), .m_BVALID_i(m_BVALID_i), .m_BREADY_o(m_BREADY_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK_i = ~ACLK_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0]    exp_q[$];
  logic [AWD+2:0]   exp_aw_q[$];

  bit   stall_en = 1'b0;
  int   err_burst = -1;
  int   pg_left = 0;
  int   pending_b = 0;
  int   b_idx = 0;
  bit   pg_hs_seen = 1'b0;
  bit   b_hs_seen = 1'b0;
  bit   b_check = 1'b0;
  logic err_exp = 1'b0;
  int   aw_cnt = 0, w_cnt = 0, wlast_cnt = 0, done_cnt = 0;
  int   w_in_burst = 0;
  logic [2:0]     cur_len = 3'd0;
  bit             aw_stall_prev = 1'b0;
  logic [AWD-1:0] held_addr = '0;
  logic [2:0]     held_len = '0;
  logic           done_prev = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor (negedge: values stable for the coming edge) ----------------
  always @(negedge ACLK_i) begin
    if (!ARESET_i) begin
      logic [AWD+2:0] e;
      if (b_check) begin
        chk("err_after_b", DW'(err_o), DW'(err_exp));
        b_check = 1'b0;
      end
      chk("chan_exclusive", DW'($countones({m_AWVALID_o, m_WVALID_o, m_BREADY_o}) <= 1), DW'(1'b1));
      chk("pg_ready_in_data", DW'(pg_ready_o && (dbg_state_o != ST_DATA)), DW'(1'b0));
      if (aw_stall_prev) begin
        chk("aw_hold_valid", DW'(m_AWVALID_o), DW'(1'b1));
        chk("aw_hold_addr", DW'(m_AWADDR_o), DW'(held_addr));
        chk("aw_hold_len", DW'(m_AWLEN_o), DW'(held_len));
      end
      aw_stall_prev = m_AWVALID_o && !m_AWREADY_i;
      held_addr = m_AWADDR_o;
      held_len  = m_AWLEN_o;

      if (m_AWVALID_o && m_AWREADY_i) begin
        chk("aw_expected", DW'(exp_aw_q.size() != 0), DW'(1'b1));
        if (exp_aw_q.size() != 0) begin
          e = exp_aw_q.pop_front();
          chk("aw_addr", DW'(m_AWADDR_o), DW'(e[AWD+2:3]));
          chk("aw_len", DW'(m_AWLEN_o), DW'(e[2:0]));
          cur_len = e[2:0];
        end
        w_in_burst = 0;
        aw_cnt++;
      end

      if (m_WVALID_o && m_WREADY_i) begin
        chk("w_expected", DW'(exp_q.size() != 0), DW'(1'b1));
        if (exp_q.size() != 0) chk("w_data", m_WDATA_o, exp_q.pop_front());
        chk("w_last", DW'(m_WLAST_o), DW'(w_in_burst == int'(cur_len)));
        if (m_WLAST_o) wlast_cnt++;
        if (w_in_burst == int'(cur_len)) begin
          pending_b++;
          w_in_burst = 0;
        end else begin
          w_in_burst++;
        end
        w_cnt++;
      end

      if (pg_valid_i && pg_ready_o) pg_hs_seen = 1'b1;

      if (m_BVALID_i && m_BREADY_o) begin
        b_hs_seen = 1'b1;
        pending_b--;
        if (m_BRESP_i != 2'b00) err_exp = 1'b1;
        b_idx++;
        b_check = 1'b1;
      end

      if (frame_done_o) begin
        chk("done_single_cycle", DW'(done_prev), DW'(1'b0));
        done_cnt++;
      end
      done_prev = frame_done_o;
    end
  end

  // ---------------- driver: pg source and AXI slave (posedge + 1) ----------------
  always @(posedge ACLK_i) begin
    #1;
    if (!ARESET_i) begin
      m_AWREADY_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      m_WREADY_i  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pg_hs_seen) pg_valid_i = 1'b0;
      pg_hs_seen = 1'b0;
      if (!pg_valid_i && pg_left > 0 && (!stall_en || $urandom_range(0, 1) == 1)) begin
        for (int i = 0; i < 8; i++) pg_data_i[i*32 +: 32] = $urandom();
        pg_valid_i = 1'b1;
        pg_left--;
        exp_q.push_back(pg_data_i);
      end
      if (b_hs_seen) m_BVALID_i = 1'b0;
      b_hs_seen = 1'b0;
      if (!m_BVALID_i && pending_b > 0 && (!stall_en || $urandom_range(0, 1) == 1)) begin
        m_BVALID_i = 1'b1;
        m_BRESP_i  = (b_idx == err_burst) ? 2'b10 : 2'b00;
      end
    end
  end

  // ---------------- directed-step tasks ----------------
  task automatic clr_counts();
    aw_cnt = 0; w_cnt = 0; wlast_cnt = 0; done_cnt = 0; b_idx = 0;
  endtask

  task automatic start_frame(input logic [AWD-1:0] base, input int beats);
    logic [AWD-1:0] a;
    int rem, len;
    a = {base[AWD-1:8], 8'h00};
    rem = beats;
    while (rem > 0) begin
      len = (rem >= 8) ? 8 : rem;
      exp_aw_q.push_back({a, 3'(len - 1)});
      a = a + AWD'(len * 32);
      rem = rem - len;
    end
    @(posedge ACLK_i); #1;
    frame_base_i  = base;
    frame_beats_i = FBW'(beats);
    frame_start_i = 1'b1;
    err_exp = 1'b0;
    pg_left = beats;
    @(posedge ACLK_i); #1;
    frame_start_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge ACLK_i);
      n++;
    end
    chk("done_within_budget", DW'(done_cnt >= target), DW'(1'b1));
    repeat (2) @(negedge ACLK_i);
  endtask

  task automatic end_checks(input string tag, input int bursts, input int beats, input logic err_req);
    chk({tag, "_aw_count"}, DW'(aw_cnt), DW'(bursts));
    chk({tag, "_w_count"}, DW'(w_cnt), DW'(beats));
    chk({tag, "_wlast_count"}, DW'(wlast_cnt), DW'(bursts));
    chk({tag, "_done_count"}, DW'(done_cnt), DW'(1));
    chk({tag, "_data_left"}, DW'(exp_q.size()), DW'(0));
    chk({tag, "_aw_left"}, DW'(exp_aw_q.size()), DW'(0));
    chk({tag, "_err"}, DW'(err_o), DW'(err_req));
    chk({tag, "_idle"}, DW'(busy_o), DW'(1'b0));
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_awvalid"}, DW'(m_AWVALID_o), DW'(1'b0));
    chk({tag, "_wvalid"}, DW'(m_WVALID_o), DW'(1'b0));
    chk({tag, "_bready"}, DW'(m_BREADY_o), DW'(1'b0));
    chk({tag, "_pg_ready"}, DW'(pg_ready_o), DW'(1'b0));
    chk({tag, "_busy"}, DW'(busy_o), DW'(1'b0));
    chk({tag, "_done"}, DW'(frame_done_o), DW'(1'b0));
    chk({tag, "_err"}, DW'(err_o), DW'(1'b0));
  endtask

  task automatic flush_tb();
    pg_valid_i = 1'b0; pg_left = 0; m_BVALID_i = 1'b0; m_BRESP_i = 2'b00;
    pending_b = 0; pg_hs_seen = 1'b0; b_hs_seen = 1'b0; b_check = 1'b0;
    aw_stall_prev = 1'b0; done_prev = 1'b0;
    exp_q.delete();
    exp_aw_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    ARESET_i = 1'b1;
    frame_start_i = 1'b0; frame_base_i = '0; frame_beats_i = '0;
    pg_data_i = '0; pg_valid_i = 1'b0;
    m_AWREADY_i = 1'b0; m_WREADY_i = 1'b0;
    m_BID_i = 3'd0; m_BRESP_i = 2'b00; m_BVALID_i = 1'b0;
    repeat (3) @(posedge ACLK_i);
    @(negedge ACLK_i);
    check_quiet("reset");
    chk("reset_awaddr", DW'(m_AWADDR_o), DW'(0));
    chk("reset_awlen", DW'(m_AWLEN_o), DW'(0));
    chk("reset_wlast", DW'(m_WLAST_o), DW'(1'b0));
    chk("const_awid", DW'(m_AWID_o), DW'(3'd0));
    chk("const_awsize", DW'(m_AWSIZE_o), DW'(3'b101));
    chk("const_awburst", DW'(m_AWBURST_o), DW'(2'b01));
    ARESET_i = 1'b0;

    // Full frame, no back-pressure.
    clr_counts();
    start_frame(32'h1000_0000, 2400);
    wait_done(1, 10000);
    end_checks("full", 300, 2400, 1'b0);

    // Unaligned base, partial last burst, start pulse while busy is ignored.
    clr_counts();
    start_frame(32'h2000_00FF, 19);
    repeat (3) @(posedge ACLK_i);
    #1;
    chk("busy_mid_frame", DW'(busy_o), DW'(1'b1));
    frame_base_i = 32'h5000_0000; frame_beats_i = 12'd100; frame_start_i = 1'b1;
    @(posedge ACLK_i); #1;
    frame_start_i = 1'b0;
    wait_done(1, 500);
    end_checks("short", 3, 19, 1'b0);

    // Random stalls on every channel.
    clr_counts();
    stall_en = 1'b1;
    start_frame(32'h3000_0400, 64);
    wait_done(1, 3000);
    end_checks("stall", 8, 64, 1'b0);
    stall_en = 1'b0;

    // SLVERR on the second burst: sticky, frame still completes.
    clr_counts();
    err_burst = 1;
    start_frame(32'h0800_0000, 32);
    wait_done(1, 500);
    end_checks("slverr", 4, 32, 1'b1);
    err_burst = -1;
    clr_counts();
    start_frame(32'h0900_0000, 8);
    chk("err_cleared_by_start", DW'(err_o), DW'(1'b0));
    wait_done(1, 200);
    end_checks("after_err", 1, 8, 1'b0);

    // Zero-beat frame: straight to DONE with no AW traffic.
    clr_counts();
    @(posedge ACLK_i); #1;
    frame_base_i = 32'h0A00_0000; frame_beats_i = '0; frame_start_i = 1'b1;
    lat = 0;
    while (!frame_done_o && lat < 5) begin
      @(posedge ACLK_i); #1;
      frame_start_i = 1'b0;
      lat++;
    end
    frame_start_i = 1'b0;
    chk("zero_done_latency", DW'(lat >= 1 && lat <= 2), DW'(1'b1));
    repeat (3) @(negedge ACLK_i);
    chk("zero_aw_count", DW'(aw_cnt), DW'(0));
    chk("zero_done_count", DW'(done_cnt), DW'(1));

    // Reset in the middle of a burst, then a clean frame on a new base.
    clr_counts();
    start_frame(32'h0B00_0000, 16);
    lat = 0;
    while (w_cnt < 4 && lat < 200) begin
      @(negedge ACLK_i);
      lat++;
    end
    chk("reached_beat4", DW'(w_cnt >= 4), DW'(1'b1));
    @(posedge ACLK_i); #3;
    ARESET_i = 1'b1;
    flush_tb();
    #1;
    check_quiet("async_reset");
    repeat (2) @(posedge ACLK_i);
    @(negedge ACLK_i);
    ARESET_i = 1'b0;
    clr_counts();
    start_frame(32'h0C00_0040, 16);
    wait_done(1, 500);
    end_checks("post_reset", 2, 16, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_frame_wdma.md
Name: axi4_frame_wdma

Overview:
AXI4 write master that pushes a full camera frame out as 256-bit pixel groups into an AXI4 write slave, such as the frame-fetch block or a memory controller. It is the initiator end of the same AW/W/B interface the frame-fetch block responds on. It accepts a valid/ready pixel-group stream from the ISP/DMA side, slices it into INCR bursts, drives AW/W and consumes B. One burst is in flight at a time.

Parameters:
- MST_ID_W, 3, AWID width
- DATA_WIDTH, 256, W data width (32 bytes/beat)
- ADDR_WIDTH, 32, address width
- TRANS_BURST_W, 2, AWBURST width
- TRANS_DATA_LEN_W, 3, AWLEN width; max burst = 2^W = 8 beats
- TRANS_DATA_SIZE_W, 3, AWSIZE width
- TRANS_WR_RESP_W, 2, BRESP width
- FRAME_BEATS_W, 12, width of the frame beat count (2400 beats = 320x240x8b)
- MST_ID, 0, constant AWID value

Ports:
- ACLK_i  in  1  clock
- ARESET_i  in  1  asynchronous, active-high reset
- frame_start_i  in  1  start pulse; sampled only in IDLE
- frame_base_i  in  ADDR_WIDTH  frame byte base address
- frame_beats_i  in  FRAME_BEATS_W  beats in frame
- pg_data_i  in  DATA_WIDTH  pixel group
- pg_valid_i  in  1  pixel group valid
- pg_ready_o  out  1  pixel group accepted
- m_AWID_o  out  MST_ID_W  = MST_ID
- m_AWADDR_o  out  ADDR_WIDTH  burst address
- m_AWLEN_o  out  TRANS_DATA_LEN_W  beats-1
- m_AWSIZE_o  out  TRANS_DATA_SIZE_W  constant 3'b101
- m_AWBURST_o  out  TRANS_BURST_W  constant 2'b01 (INCR)
- m_AWVALID_o  out  1
- m_AWREADY_i  in  1
- m_WDATA_o  out  DATA_WIDTH
- m_WLAST_o  out  1
- m_WVALID_o  out  1
- m_WREADY_i  in  1
- m_BID_i  in  MST_ID_W
- m_BRESP_i  in  TRANS_WR_RESP_W
- m_BVALID_i  in  1
- m_BREADY_o  out  1
- busy_o  out  1  not IDLE
- frame_done_o  out  1  one-cycle pulse at frame end
- err_o  out  1  sticky error: BRESP!=OKAY or BID mismatch

Behaviour:
- Reset (async, ARESET_i=1): state=IDLE. All outputs 0 except constant fields (AWID/AWSIZE/AWBURST). err_o clears. Reset mid-burst abandons the transaction with no completion; the slave is reset system-wide at the same time.
- FSM IDLE -> ADDR -> DATA -> RESP -> {ADDR | DONE} -> IDLE.
- IDLE: frame_start_i=1 latches base (low 8 bits forced 0, i.e. 256 B aligned, so no 4 KB crossing) and remaining=frame_beats_i, and clears err_o.
  - If frame_beats_i=0: go to DONE with no AXI traffic.
  - frame_start_i outside IDLE is ignored.
- ADDR: m_AWVALID_o=1, AWADDR=current, AWLEN=min(remaining,8)-1. AWADDR/AWLEN are stable while valid. On AWVALID&&AWREADY, go to DATA with beat_cnt=0.
- DATA: W channel bridged to the pg stream; a W handshake consumes one pixel group. WLAST=1 when beat_cnt==AWLEN. On the last handshake: remaining -= AWLEN+1, addr += (AWLEN+1)*32, go to RESP. Back-pressure is honoured on both sides. pg_ready_o=0 outside DATA.
- RESP: m_BREADY_o=1. On BVALID set err_o if BRESP!=2'b00 or BID!=MST_ID. Next state is ADDR if remaining>0, else DONE. Errors do not abort the frame.
- DONE: frame_done_o=1 for exactly one cycle, then IDLE.
- AWVALID, WVALID and BREADY are never asserted simultaneously. A frame of N beats produces ceil(N/8) bursts.
- The counter width is FRAME_BEATS_W; remaining never underflows.

Optional Feature:
- AXI4_FRAME_WDMA_SKID_EN defined: a 2-entry skid buffer sits between pg_* and W.
  - pg_ready_o is registered, with no combinational path from m_WREADY_i.
  - m_WDATA_o/m_WVALID_o are registered outputs.
  - First-beat latency is +1 cycle; sustained throughput is 1 beat/cycle.
  - The buffer may prefetch at most 2 beats during DATA only; it never prefetches beyond the current burst.
- Undefined: combinational bridge. m_WVALID_o=pg_valid_i&&DATA, pg_ready_o=m_WREADY_i&&DATA, m_WDATA_o=pg_data_i.

Decomposition:
- Package axi4_frame_wdma_pkg: FSM state enum; AXI_SIZE_32B=3'b101, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00; BURST_MAX_BEATS=8; BEAT_BYTES=32.
- Sub-module axi4_wdma_skid (2-entry valid/ready skid buffer), instantiated only under AXI4_FRAME_WDMA_SKID_EN.

Test Plan:
- Base 0x1000_0000, 2400 beats, WREADY/AWREADY/BVALID held 1: exactly 300 AW handshakes. AWADDR=0x1000_0000+256*k, AWLEN=7. 2400 W beats with 300 WLAST. Data matches the input in order. frame_done_o pulses once; err_o=0.
- 19 beats, base 0x2000_00FF: AWADDR 0x2000_0000/0x100/0x200 with AWLEN 7/7/2. WLAST on beats 8, 16, 19.
- Random WREADY, pg_valid_i and AWREADY stalls (50%) on a 64-beat frame: no beat lost or duplicated, AW fields stable while stalled, pg_ready_o only in DATA.
- BRESP=2'b10 on burst 2 of a 4-burst frame: err_o rises after that B and stays 1, the remaining bursts still complete, and the next frame_start_i clears it.
- frame_beats_i=0: no AWVALID; frame_done_o 2 cycles after start. frame_start_i pulsed while busy: ignored, burst count unchanged.
- ARESET_i asserted mid-DATA (beat 4 of a burst): all valids/readies drop asynchronously, busy_o=0. A new frame after release starts at AWLEN=7 on the new base.
